// File: rtl/mmio_str_reader.sv
// Snoops a CPU write bus: posts integer writes, and for a string-address write walks
// 16-bit words in memory, streaming the low byte of each word until a zero word.
module mmio_str_reader #(
  parameter logic [15:0] INT_ADDR = 16'h1000,
  parameter logic [15:0] STR_ADDR = 16'h1002,
  parameter int unsigned MAX_LEN  = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_cpu_addr,
  input  logic        i_cpu_wr,
  input  logic [15:0] i_cpu_wrdata,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  input  logic [15:0] i_mem_rddata,
  output logic        o_int_valid,
  output logic [15:0] o_int_data,
  output logic [7:0]  o_char,
  output logic        o_char_valid,
  input  logic        i_char_ready,
  output logic        o_str_done,
  output logic        o_str_err,
  output logic [9:0]  o_str_len,
  output logic        o_busy,
  output logic        o_drop
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_EMIT    = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  localparam logic [9:0] MAX_CNT = 10'(MAX_LEN);

  state_t      r_state;
  logic [15:0] r_ptr;
  logic [9:0]  r_count;
  logic        r_ok;
  logic [15:0] r_mem_addr;
  logic        r_mem_rd;
  logic        r_int_valid;
  logic [15:0] r_int_data;
  logic [7:0]  r_char;
  logic        r_char_valid;
  logic        r_str_done;
  logic        r_str_err;
  logic [9:0]  r_str_len;
  logic        r_busy;
  logic        r_drop;

  logic        w_int_wr;
  logic        w_str_wr;
  logic [15:0] w_str_ptr;
  logic [9:0]  w_cnt_inc;
  logic [15:0] w_ptr_inc;

  assign w_int_wr  = i_cpu_wr && (i_cpu_addr == INT_ADDR);
  assign w_str_wr  = i_cpu_wr && (i_cpu_addr == STR_ADDR);
  // Strings are word aligned: the low address bit of the CPU data is discarded.
  assign w_str_ptr = i_cpu_wrdata & 16'hFFFE;
  assign w_cnt_inc = r_count + 10'd1;
  assign w_ptr_inc = r_ptr + 16'd2;

  // Integer post path, string-walk FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= 16'h0000;
      r_count      <= 10'd0;
      r_ok         <= 1'b0;
      r_mem_addr   <= 16'h0000;
      r_mem_rd     <= 1'b0;
      r_int_valid  <= 1'b0;
      r_int_data   <= 16'h0000;
      r_char       <= 8'h00;
      r_char_valid <= 1'b0;
      r_str_done   <= 1'b0;
      r_str_err    <= 1'b0;
      r_str_len    <= 10'd0;
      r_busy       <= 1'b0;
      r_drop       <= 1'b0;
    end else begin
      r_int_valid <= 1'b0;
      r_drop      <= 1'b0;
      r_str_done  <= 1'b0;
      r_str_err   <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= 16'h0000;

      if (w_int_wr) begin
        r_int_data  <= i_cpu_wrdata;
        r_int_valid <= 1'b1;
      end

      if (w_str_wr && (r_state != S_IDLE)) begin
        r_drop <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_str_wr) begin
            r_ptr      <= w_str_ptr;
            r_count    <= 10'd0;
            r_mem_rd   <= 1'b1;
            r_mem_addr <= w_str_ptr;
            r_busy     <= 1'b1;
            r_state    <= S_RD_REQ;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_RD_REQ: begin
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (i_mem_rddata == 16'h0000) begin
            r_ok    <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_char       <= i_mem_rddata[7:0];
            r_char_valid <= 1'b1;
            r_state      <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (i_char_ready) begin
            r_char_valid <= 1'b0;
            r_count      <= w_cnt_inc;
            r_ptr        <= w_ptr_inc;
            if (w_cnt_inc == MAX_CNT) begin
              r_ok    <= 1'b0;
              r_state <= S_FINISH;
            end else begin
              r_mem_rd   <= 1'b1;
              r_mem_addr <= w_ptr_inc;
              r_state    <= S_RD_REQ;
            end
          end else begin
            r_state <= S_EMIT;
          end
        end
        S_FINISH: begin
          r_str_done <= r_ok;
          r_str_err  <= !r_ok;
          r_str_len  <= r_count;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_char_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign o_mem_addr   = r_mem_addr;
  assign o_mem_rd     = r_mem_rd;
  assign o_int_valid  = r_int_valid;
  assign o_int_data   = r_int_data;
  assign o_char       = r_char;
  assign o_char_valid = r_char_valid;
  assign o_str_done   = r_str_done;
  assign o_str_err    = r_str_err;
  assign o_str_len    = r_str_len;
  assign o_busy       = r_busy;
  assign o_drop       = r_drop;

endmodule

// File: doc/mmio_str_reader.md
MMIO_STR_READER -- requirements
Module: mmio_str_reader

Interface
REQ-001 SHALL have parameter INT_ADDR, 16'h1000, CPU write address that posts an integer result.
REQ-002 SHALL have parameter STR_ADDR, 16'h1002, CPU write address whose data is a string start address.
REQ-003 SHALL have parameter MAX_LEN, 512, maximum characters before a string is declared unterminated.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-low reset (reset==0 resets on the clock edge).
REQ-006 SHALL have ports i_cpu_addr in 16, i_cpu_wr in 1, i_cpu_wrdata in 16: snooped CPU write bus.
REQ-007 SHALL have ports o_mem_addr out 16, o_mem_rd out 1: memory read request.
REQ-008 SHALL have port i_mem_rddata  in  16  read data, valid the cycle after o_mem_rd is sampled.
REQ-009 SHALL have ports o_int_valid out 1 (one-cycle pulse) and o_int_data out 16: posted integer.
REQ-010 SHALL have ports o_char out 8, o_char_valid out 1, i_char_ready in 1: character stream.
REQ-011 SHALL have ports o_str_done out 1, o_str_err out 1, o_str_len out 10, o_busy out 1, o_drop out 1.

Function
REQ-012 SHALL, on a clock edge with i_cpu_wr=1 and i_cpu_addr==INT_ADDR, register i_cpu_wrdata into o_int_data and pulse o_int_valid high for exactly the following cycle, in any FSM state.
REQ-013 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, EMIT, FINISH.
REQ-014 SHALL, in IDLE on an edge with i_cpu_wr=1 and i_cpu_addr==STR_ADDR, latch {i_cpu_wrdata[15:1],1'b0} as pointer, clear the character count, and go to RD_REQ.
REQ-015 SHALL, on a STR_ADDR write while not in IDLE, ignore the write and pulse o_drop for one cycle.
REQ-016 SHALL drive o_mem_rd=1 and o_mem_addr=pointer only while in RD_REQ; o_mem_rd=0 in all other states; RD_REQ always advances to RD_WAIT next edge.
REQ-017 SHALL, at the RD_WAIT edge, capture i_mem_rddata: if the 16-bit word is 0, go to FINISH with success; otherwise load o_char=rddata[7:0] and go to EMIT.
REQ-018 SHALL hold o_char_valid=1 and o_char stable throughout EMIT until an edge with i_char_ready=1.
REQ-019 SHALL, on the EMIT handshake edge, increment count and pointer by 2 (16-bit wrap 16'hFFFE -> 16'h0000); if the new count equals MAX_LEN go to FINISH with error, else go to RD_REQ.
REQ-020 SHALL, in FINISH, pulse o_str_done (success) or o_str_err (error) for exactly one cycle with o_str_len = count, then return to IDLE.
REQ-021 SHALL hold o_str_len at its last value until the next string completes.
REQ-022 SHALL assert o_busy in every state except IDLE.
REQ-023 SHALL achieve a minimum latency of 3 cycles per character (RD_REQ, RD_WAIT, EMIT with ready high), with the first o_mem_rd in the cycle after the STR_ADDR write edge.
REQ-024 SHALL treat an empty string (first word 0) as success with o_str_len=0 and no o_char_valid.
REQ-025 SHALL ignore i_cpu_wr to all other addresses.

Reset
REQ-026 SHALL, on any edge with reset==0, force IDLE, pointer=0, count=0, o_int_data=0, o_char=0, o_str_len=0, and all of o_int_valid, o_char_valid, o_mem_rd, o_str_done, o_str_err, o_busy, o_drop to 0, aborting any string in progress without a done or err pulse.
REQ-027 SHALL give reset priority over simultaneous CPU writes on the same edge.

Verification
REQ-028 SHALL verify: write 16'h0037 to 16'h1000 -> o_int_valid high one cycle, o_int_data=16'h0037, o_busy stays 0.
REQ-029 SHALL verify: memory "Hi\0" at 16'h0100, write 16'h0100 to 16'h1002, ready tied 1 -> chars 'H','i', reads at 0100/0102/0104, o_str_done with o_str_len=2, 9 cycles from write edge to done.
REQ-030 SHALL verify: 512 nonzero words from 16'h2000, write 16'h2001 to 16'h1002 -> first read at 16'h2000, o_str_err pulse, o_str_len=512, no read at 16'h2400.
REQ-031 SHALL verify: i_char_ready held 0 for 5 cycles in EMIT -> o_char stable, no new o_mem_rd; a STR_ADDR write during this wait -> o_drop pulse, string unaffected.
REQ-032 SHALL verify: pointer 16'hFFFE with nonzero word at FFFE and 0 at 0000 -> reads FFFE then 0000, done, o_str_len=1.
REQ-033 SHALL verify: reset low mid-EMIT -> all outputs 0, IDLE next cycle, no done/err pulse; an empty string afterwards -> o_str_done, o_str_len=0.
